// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared types for the dcache <-> main-memory controller: bus command and
// access-size encodings, the queued request record, the MSHR record and the
// load-data extraction helpers.
`ifndef LSQSZ
`define LSQSZ 8
`endif

package dcache_mem_ctrl_pkg;

    localparam int LSQ_W_DEF = `LSQSZ;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_e;

    // One queued memory request. Loads keep the line-aligned address plus the
    // original byte offset and size so the MSHR can rebuild the load result.
    typedef struct packed {
        bus_cmd_e              cmd;
        logic [15:0]           addr;
        logic [63:0]           data;
        mem_size_e             size;
        logic [LSQ_W_DEF-1:0]  gnt;
        logic [2:0]            off;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [3:0]            tag;
        logic [15:0]           addr;
        mem_size_e             size;
        logic [LSQ_W_DEF-1:0]  gnt;
    } mshr_t;

    function automatic logic [63:0] size_mask(input mem_size_e sz);
        logic [63:0] m;
        case (sz)
            BYTE:    m = 64'h0000_0000_0000_00FF;
            HALF:    m = 64'h0000_0000_0000_FFFF;
            WORD:    m = 64'h0000_0000_FFFF_FFFF;
            DOUBLE:  m = 64'hFFFF_FFFF_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] load_extract(input logic [63:0] line,
                                                 input logic [2:0]  off,
                                                 input mem_size_e   sz);
        return (line >> {off, 3'b000}) & size_mask(sz);
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue: up to three pushes per cycle (lanes packed in lane order
// behind the write pointer), one pop per cycle. An explicit occupancy count
// separates full from empty; count_next lets the owner look one cycle ahead.
module mem_req_fifo
    import dcache_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       push_en,
    input  mem_req_t [2:0]   push_req,
    input  logic             pop,
    output mem_req_t         head,
    output logic [AW:0]      count,
    output logic [AW:0]      count_next
);

    localparam int CW = AW + 1;

    mem_req_t       mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [AW-1:0]  slot_s [3];
    logic [1:0]     push_cnt_s;

    // Compact the valid lanes into consecutive slots behind the write pointer
    always_comb begin
        slot_s[0]  = wr_ptr_r;
        slot_s[1]  = wr_ptr_r + AW'(push_en[0]);
        slot_s[2]  = wr_ptr_r + AW'(push_en[0]) + AW'(push_en[1]);
        push_cnt_s = 2'(push_en[0]) + 2'(push_en[1]) + 2'(push_en[2]);
        count_next = count_r + CW'(push_cnt_s) - CW'(pop);
    end

    // Entry storage; occupancy is tracked by the count, so no reset is needed
    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (push_en[i]) begin
                mem_r[slot_s[i]] <= push_req[i];
            end
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push_cnt_s);
            rd_ptr_r <= rd_ptr_r + AW'(pop);
            count_r  <= count_next;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/dcache_mem_ctrl.sv
// dcache main-memory sequencer: queues write-backs, store misses and load
// misses in arrival order, issues them one per cycle on the memory bus,
// tracks outstanding loads in MSHRs and completes them on tagged responses.
module dcache_mem_ctrl
    import dcache_mem_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_MSHR   = 4,
    parameter int LSQ_W      = LSQ_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [15:0]       wb_addr,
    input  logic [63:0]       wb_data,
    input  logic              wr_en,
    input  logic [15:0]       wr_addr,
    input  logic [63:0]       wr_data,
    input  logic [1:0]        wr_size,
    input  logic              rd_en,
    input  logic [15:0]       rd_addr,
    input  logic [1:0]        rd_size,
    input  logic [LSQ_W-1:0]  rd_gnt,
    output logic              stall,
    output logic [1:0]        proc2mem_command,
    output logic [31:0]       proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    output logic [1:0]        proc2mem_size,
    input  logic [3:0]        mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [3:0]        mem2proc_tag,
    output logic              fill_en,
    output logic [4:0]        fill_idx,
    output logic [7:0]        fill_tag,
    output logic [63:0]       fill_data,
    output logic [63:0]       ld_data,
    output logic [LSQ_W-1:0]  ld_feedback,
    output logic              idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    logic [2:0]      push_en_s;
    mem_req_t [2:0]  push_req_s;
    logic            pop_s;
    logic            alloc_s;
    mem_req_t        head_s;
    logic [CW-1:0]   count_s;
    logic [CW-1:0]   count_next_s;
    mshr_t           mshr_r [NUM_MSHR];
    logic            mshr_free_s;
    logic            mshr_busy_s;
    logic [MW-1:0]   alloc_idx_s;
    logic            hit_s;
    logic [MW-1:0]   hit_idx_s;
    logic [1:0]      state_s;
    logic            stall_r;

    // Build the three enqueue lanes in fixed order: write-back, store, load
    always_comb begin
        push_en_s = {rd_en, wr_en, wb_en};

        push_req_s[0].cmd  = BUS_STORE;
        push_req_s[0].addr = wb_addr;
        push_req_s[0].data = wb_data;
        push_req_s[0].size = DOUBLE;
        push_req_s[0].gnt  = '0;
        push_req_s[0].off  = 3'd0;

        push_req_s[1].cmd  = BUS_STORE;
        push_req_s[1].addr = wr_addr;
        push_req_s[1].data = wr_data;
        push_req_s[1].size = mem_size_e'(wr_size);
        push_req_s[1].gnt  = '0;
        push_req_s[1].off  = 3'd0;

        push_req_s[2].cmd  = BUS_LOAD;
        push_req_s[2].addr = {rd_addr[15:3], 3'b000};
        push_req_s[2].data = 64'h0;
        push_req_s[2].size = mem_size_e'(rd_size);
        push_req_s[2].gnt  = rd_gnt;
        push_req_s[2].off  = rd_addr[2:0];
    end

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_en    (push_en_s),
        .push_req   (push_req_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (count_s),
        .count_next (count_next_s)
    );

    // Lowest free MSHR for allocation, any-busy for idle, and response tag match
    always_comb begin
        mshr_free_s = 1'b0;
        mshr_busy_s = 1'b0;
        alloc_idx_s = '0;
        hit_s       = 1'b0;
        hit_idx_s   = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!mshr_r[i].valid) begin
                mshr_free_s = 1'b1;
                alloc_idx_s = MW'(i);
            end else begin
                mshr_busy_s = 1'b1;
            end
            if (mshr_r[i].valid && (mem2proc_tag != 4'd0) && (mshr_r[i].tag == mem2proc_tag)) begin
                hit_s     = 1'b1;
                hit_idx_s = MW'(i);
            end
        end
    end

    // Issue state: a load at the head waits for an MSHR, blocking everything behind it
    always_comb begin
        if (count_s == CW'(0)) begin
            state_s = ST_IDLE;
        end else if ((head_s.cmd == BUS_LOAD) && !mshr_free_s) begin
            state_s = ST_BLOCKED;
        end else begin
            state_s = ST_ISSUE;
        end
    end

    // Present the head on the bus; pop only when memory accepts it
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = 32'h0;
        proc2mem_data    = 64'h0;
        proc2mem_size    = BYTE;
        pop_s            = 1'b0;
        alloc_s          = 1'b0;
        case (state_s)
            ST_ISSUE: begin
                proc2mem_command = head_s.cmd;
                proc2mem_addr    = {16'h0000, head_s.addr};
                proc2mem_data    = head_s.data;
                proc2mem_size    = (head_s.cmd == BUS_LOAD) ? DOUBLE : head_s.size;
                pop_s            = (mem2proc_response != 4'd0);
                alloc_s          = (mem2proc_response != 4'd0) && (head_s.cmd == BUS_LOAD);
            end
            ST_IDLE, ST_BLOCKED: begin
                proc2mem_command = BUS_NONE;
            end
            default: begin
                proc2mem_command = BUS_NONE;
            end
        endcase
    end

    // MSHR table: free on a matching response, allocate on an accepted load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                mshr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (hit_s && (hit_idx_s == MW'(i))) begin
                    mshr_r[i].valid <= 1'b0;
                end
                if (alloc_s && (alloc_idx_s == MW'(i))) begin
                    mshr_r[i].valid <= 1'b1;
                    mshr_r[i].tag   <= mem2proc_response;
                    mshr_r[i].addr  <= {head_s.addr[15:3], head_s.off};
                    mshr_r[i].size  <= head_s.size;
                    mshr_r[i].gnt   <= head_s.gnt;
                end
            end
        end
    end

    // Complete a load in the cycle its tagged response arrives
    always_comb begin
        if (hit_s) begin
            fill_en     = 1'b1;
            fill_idx    = mshr_r[hit_idx_s].addr[7:3];
            fill_tag    = mshr_r[hit_idx_s].addr[15:8];
            fill_data   = mem2proc_data;
            ld_data     = load_extract(mem2proc_data, mshr_r[hit_idx_s].addr[2:0], mshr_r[hit_idx_s].size);
            ld_feedback = mshr_r[hit_idx_s].gnt;
        end else begin
            fill_en     = 1'b0;
            fill_idx    = 5'd0;
            fill_tag    = 8'd0;
            fill_data   = 64'h0;
            ld_data     = 64'h0;
            ld_feedback = '0;
        end
    end

    // Back-pressure: fewer than three slots free after this cycle's push and pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_r <= 1'b0;
        end else begin
            stall_r <= ((CW'(FIFO_DEPTH) - count_next_s) < CW'(3));
        end
    end

    assign stall = stall_r;
    assign idle  = (count_s == CW'(0)) && !mshr_busy_s;

endmodule
